matmul_sequencer: RTL and testbench

Control block for the TPU matrix-multiply pass. It sits between the host address decoder and the A/B memories plus systolic array. On a MatMul command it:
- drives the memory shift enables and the systolic enable for exactly 3·DIM−2 cycles;
- zero-pads the A/B inputs after the first DIM cycles;
- stalls host A/B/C accesses while the pass is in flight;
- signals completion with a one-cycle pulse.

---
 rtl/matmul_sequencer.sv | 93 +++++++++
 tb/tb_matmul_sequencer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// Matrix-multiply pass sequencer: IDLE -> RUN (3*DIM-2 cycles) -> DONE, with host arbitration.
// Optional completed-run counter enabled by defining MATMUL_PERF_CNT_EN.
module matmul_sequencer #(
  parameter int unsigned DIM  = 8,
  parameter int unsigned CNTW = $clog2(3 * DIM - 2) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            host_req,
  output logic            host_grant,
  output logic            host_stall,
  output logic            mem_en,
  output logic            sys_en,
  output logic            zero_pad,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] run_cycle,
  output logic [15:0]     matmul_count
);

  localparam logic [CNTW-1:0] LAST_CYCLE = CNTW'(3 * DIM - 3);
  localparam logic [CNTW-1:0] PAD_FROM   = CNTW'(DIM);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    mem_en   = 1'b0;
    sys_en   = 1'b0;
    zero_pad = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        mem_en   = 1'b1;
        sys_en   = 1'b1;
        busy     = 1'b1;
        zero_pad = (cnt_q >= PAD_FROM);
        // Counter is cleared on the way into DONE so run_cycle reads 0 there.
        if (cnt_q == LAST_CYCLE) state_d = DONE;
        else cnt_d = cnt_q + CNTW'(1);
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign run_cycle  = cnt_q;
  assign host_grant = host_req & (state_q != RUN);
  assign host_stall = host_req & ~host_grant;

`ifdef MATMUL_PERF_CNT_EN
  logic [15:0] mcount_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcount_q <= '0;
    end else if ((state_q == DONE) && (mcount_q != '1)) begin
      mcount_q <= mcount_q + 16'd1;
    end
  end

  assign matmul_count = mcount_q;
`else
  assign matmul_count = '0;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer (DIM=8): stimulus pushes per-cycle expectations, monitor compares.
module tb_matmul_sequencer;
  localparam int DIM  = 8;
  localparam int RUNC = 3 * DIM - 2;
  localparam int CNTW = $clog2(3 * DIM - 2) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            host_req = 1'b0;
  logic            host_grant, host_stall, mem_en, sys_en, zero_pad, busy, done;
  logic [CNTW-1:0] run_cycle;
  logic [15:0]     matmul_count;

  matmul_sequencer #(.DIM(DIM), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .start(start), .host_req(host_req),
    .host_grant(host_grant), .host_stall(host_stall), .mem_en(mem_en),
    .sys_en(sys_en), .zero_pad(zero_pad), .busy(busy), .done(done),
    .run_cycle(run_cycle), .matmul_count(matmul_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic grant, stall, mem, sys, zp, bsy, dn;
    int   rc;
    int   mc;
    int   tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   pos = 0;      // 0 idle, 1..RUNC run position, RUNC+1 done cycle
  int   cnt = 0;      // expected completed-run count
  int   cyc = 0;
  int   done_seen = 0;

  task automatic chk(input string name, input int tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %0d expected %0d", name, tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs the spec requires for that cycle.
  task automatic step(input logic st, input logic rq, input logic rs);
    exp_t e;
    logic running;
    @(posedge clk);
    #1;
    start = st; host_req = rq; rst = rs;
    running = (pos >= 1) && (pos <= RUNC);
    e.grant = rq & ~running;
    e.stall = rq & running;
    e.mem   = running;
    e.sys   = running;
    e.bsy   = running;
    e.zp    = (pos >= DIM + 1) && (pos <= RUNC);
    e.dn    = (pos == RUNC + 1);
    e.rc    = running ? pos - 1 : 0;
`ifdef MATMUL_PERF_CNT_EN
    e.mc    = cnt;
`else
    e.mc    = 0;
`endif
    e.tag   = cyc;
    q.push_back(e);
    cyc++;
    if (rs) begin
      pos = 0;
      cnt = 0;
    end else begin
      if (pos == RUNC + 1 && cnt < 65535) cnt++;
      if (pos == 0) pos = st ? 1 : 0;
      else if (pos <= RUNC) pos++;
      else pos = 0;
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (done) done_seen++;
      chk("host_grant",   e.tag, int'(host_grant),   int'(e.grant));
      chk("host_stall",   e.tag, int'(host_stall),   int'(e.stall));
      chk("mem_en",       e.tag, int'(mem_en),       int'(e.mem));
      chk("sys_en",       e.tag, int'(sys_en),       int'(e.sys));
      chk("zero_pad",     e.tag, int'(zero_pad),     int'(e.zp));
      chk("busy",         e.tag, int'(busy),         int'(e.bsy));
      chk("done",         e.tag, int'(done),         int'(e.dn));
      chk("run_cycle",    e.tag, int'(run_cycle),    e.rc);
      chk("matmul_count", e.tag, int'(matmul_count), e.mc);
    end
  end

  initial begin
    int d0;
    repeat (2) @(posedge clk);
    // Reset state, then idle with host_req high.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    // Single run with host_req held high throughout.
    step(1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= RUNC + 3; i++) step(1'b0, 1'b1, 1'b0);

    // Starts at T+5 and T+23 (DONE) must be ignored; exactly one done.
    d0 = done_seen;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= RUNC + 6; i++) step((i == 5) || (i == RUNC + 1), 1'b0, 1'b0);
    @(negedge clk);
    chk("single_done", cyc, done_seen - d0, 1);

    // Reset at T+10 aborts the run with no done pulse.
    d0 = done_seen;
    step(1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= RUNC + 4; i++) step(1'b0, 1'b1, i == 10);
    @(negedge clk);
    chk("abort_no_done", cyc, done_seen - d0, 0);

    // start together with rst: stays idle.
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Three back-to-back runs, each start in the IDLE cycle right after done.
    d0 = done_seen;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3 * (RUNC + 2) + 4; i++) step((pos == 0) && (i < 3 * (RUNC + 2) - 1), 1'b0, 1'b0);
    @(negedge clk);
    chk("three_runs", cyc, done_seen - d0, 3);

    @(negedge clk);
    chk("queue_drained", cyc, q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
